gear_selector: RTL and testbench

- Shift-lever and gear-mode controller sitting directly upstream of the vehicle physics/RPM block.
- Converts raw lever and mode buttons into the encoded gear (3:P, 6:R, 9:N, 12:D), low-gear mode flag and max gear limit that the physics block consumes.
- Enforces brake and speed interlocks. Rejected requests produce a one-cycle reject pulse for the buzzer/LED stage.

---
 rtl/gear_selector.sv | 170 +++++++++++++++++
 tb/tb_gear_selector.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/gear_selector.sv
// rtl/gear_selector.sv - lever/mode controller with brake and speed interlocks for the physics block.
// Optional auto-park from idle N is built only when GEAR_SELECTOR_AUTO_PARK_EN is defined.
module gear_selector #(
  parameter int DB_CYCLES   = 16,
  parameter int R_SPEED_MAX = 3
`ifdef GEAR_SELECTOR_AUTO_PARK_EN
  , parameter int AUTO_PARK_CYCLES = 1024
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       engine_on,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_low,
  input  logic       btn_plus,
  input  logic       btn_minus,
  input  logic       is_brake_normal,
  input  logic       is_brake_hard,
  input  logic [7:0] speed,
  output logic [3:0] current_gear,
  output logic       is_low_gear_mode,
  output logic [2:0] max_gear_limit,
  output logic       shift_reject,
  output logic       gear_changed
);
  localparam int DBW = $clog2(DB_CYCLES + 1);

  typedef enum logic [3:0] {S_P = 4'd3, S_R = 4'd6, S_N = 4'd9, S_D = 4'd12} gear_t;

  // Button index: 0 up, 1 down, 2 low, 3 plus, 4 minus
  logic [4:0]     w_raw;
  logic [4:0]     w_ev;
  logic [4:0]     r_s1, r_s2, r_acc, r_acc_d;
  logic [DBW-1:0] r_cnt [5];

  assign w_raw = {btn_minus, btn_plus, btn_low, btn_down, btn_up};
  assign w_ev  = r_acc & ~r_acc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_acc   <= '0;
      r_acc_d <= '0;
      for (int i = 0; i < 5; i++) r_cnt[i] <= '0;
    end else begin
      r_s1    <= w_raw;
      r_s2    <= r_s1;
      r_acc_d <= r_acc;
      for (int i = 0; i < 5; i++) begin
        if (r_s2[i] == r_acc[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DBW'(DB_CYCLES - 1)) begin
          r_cnt[i] <= '0;
          r_acc[i] <= r_s2[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  gear_t      r_gear;
  gear_t      w_next;
  logic       w_ok;
  logic       w_brake;
  logic       r_low;
  logic [2:0] r_limit;
  logic       r_rej;
  logic       r_chg;

  assign w_brake = is_brake_normal | is_brake_hard;

  // Lever target and its interlock; only consulted when exactly one lever event is present.
  always_comb begin
    w_next = r_gear;
    w_ok   = 1'b0;
    if (w_ev[0]) begin
      case (r_gear)
        S_R:     begin w_next = S_P; w_ok = (speed == 8'd0); end
        S_N:     begin w_next = S_R; w_ok = (speed <= 8'(R_SPEED_MAX)); end
        S_D:     begin w_next = S_N; w_ok = 1'b1; end
        default: ;
      endcase
    end else begin
      case (r_gear)
        S_P:     begin w_next = S_R; w_ok = w_brake; end
        S_R:     begin w_next = S_N; w_ok = 1'b1; end
        S_N:     begin w_next = S_D; w_ok = 1'b1; end
        default: ;
      endcase
    end
  end

`ifdef GEAR_SELECTOR_AUTO_PARK_EN
  localparam int APW = $clog2(AUTO_PARK_CYCLES + 1);
  logic [APW-1:0] r_idle;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gear  <= S_P;
      r_low   <= 1'b0;
      r_limit <= 3'd6;
      r_rej   <= 1'b0;
      r_chg   <= 1'b0;
`ifdef GEAR_SELECTOR_AUTO_PARK_EN
      r_idle  <= '0;
`endif
    end else begin
      r_rej <= 1'b0;
      r_chg <= 1'b0;
      if (!engine_on) begin
        r_gear  <= S_P;
        r_chg   <= (r_gear != S_P);
        r_low   <= 1'b0;
        r_limit <= 3'd6;
      end else if (w_ev[0] && w_ev[1]) begin
        r_rej <= 1'b1;
      end else if (w_ev[0] || w_ev[1]) begin
        // Mode events arriving alongside a lever event are dropped here by priority.
        if (w_ok) begin
          r_gear <= w_next;
          r_chg  <= 1'b1;
          if (r_gear == S_D) begin
            r_low   <= 1'b0;
            r_limit <= 3'd6;
          end
        end else begin
          r_rej <= 1'b1;
        end
      end else if (w_ev[2]) begin
        if (r_gear == S_D) begin
          r_low   <= ~r_low;
          r_limit <= r_low ? 3'd6 : 3'd3;
        end else begin
          r_rej <= 1'b1;
        end
      end else if (r_low && (w_ev[3] ^ w_ev[4])) begin
        if (w_ev[3]) begin
          if (r_limit == 3'd6) r_rej <= 1'b1;
          else                 r_limit <= r_limit + 3'd1;
        end else begin
          if (r_limit == 3'd1) r_rej <= 1'b1;
          else                 r_limit <= r_limit - 3'd1;
        end
      end
`ifdef GEAR_SELECTOR_AUTO_PARK_EN
      if (engine_on && r_gear == S_N && speed == 8'd0 && !w_brake && w_ev == 5'd0) begin
        if (r_idle == APW'(AUTO_PARK_CYCLES - 1)) begin
          r_idle <= '0;
          r_gear <= S_P;
          r_chg  <= 1'b1;
        end else begin
          r_idle <= r_idle + 1'b1;
        end
      end else begin
        r_idle <= '0;
      end
`endif
    end
  end

  assign current_gear     = r_gear;
  assign is_low_gear_mode = r_low;
  assign max_gear_limit   = r_limit;
  assign shift_reject     = r_rej;
  assign gear_changed     = r_chg;
endmodule

// File: tb/tb_gear_selector.sv
// tb/tb_gear_selector.sv - vector table plus timed scoreboard for gear_selector.
// Auto-park sequence is exercised when GEAR_SELECTOR_AUTO_PARK_EN is defined.
module tb_gear_selector;
  localparam int DB = 16;
  localparam logic [4:0] U = 5'd1, DN = 5'd2, LO = 5'd4, PL = 5'd8, MI = 5'd16;
  localparam logic [1:0] NB = 2'b01, HB = 2'b10, NOB = 2'b00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       engine_on = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_low = 1'b0, btn_plus = 1'b0, btn_minus = 1'b0;
  logic       is_brake_normal = 1'b0, is_brake_hard = 1'b0;
  logic [7:0] speed = 8'd0;
  logic [3:0] current_gear;
  logic       is_low_gear_mode;
  logic [2:0] max_gear_limit;
  logic       shift_reject;
  logic       gear_changed;

  gear_selector #(
    .DB_CYCLES(DB),
    .R_SPEED_MAX(3)
`ifdef GEAR_SELECTOR_AUTO_PARK_EN
    , .AUTO_PARK_CYCLES(8)
`endif
  ) dut (
    .clk(clk), .rst(rst), .engine_on(engine_on),
    .btn_up(btn_up), .btn_down(btn_down), .btn_low(btn_low),
    .btn_plus(btn_plus), .btn_minus(btn_minus),
    .is_brake_normal(is_brake_normal), .is_brake_hard(is_brake_hard),
    .speed(speed), .current_gear(current_gear), .is_low_gear_mode(is_low_gear_mode),
    .max_gear_limit(max_gear_limit), .shift_reject(shift_reject), .gear_changed(gear_changed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [4:0] btn;
    logic       eng;
    logic [1:0] brk;
    logic [7:0] spd;
    logic [3:0] gear;
    logic       low;
    logic [2:0] lim;
    logic       rej;
    logic       chg;
  } vec_t;

  typedef struct {
    int         due;
    int         id;
    logic [3:0] gear;
    logic       low;
    logic [2:0] lim;
    logic       rej;
    logic       chg;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  exp_t e;

  function automatic void add(logic [4:0] b, logic en, logic [1:0] k, int s,
                              int g, logic lo, int li, logic rj, logic ch);
    vec_t v;
    v.btn = b; v.eng = en; v.brk = k; v.spd = 8'(s);
    v.gear = 4'(g); v.low = lo; v.lim = 3'(li); v.rej = rj; v.chg = ch;
    tbl.push_back(v);
  endfunction

  // Outputs are compared on the falling edge; a pulse outside a scheduled slot is an error.
  always @(negedge clk) begin
    if (!rst) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        total++;
        if (current_gear !== e.gear || is_low_gear_mode !== e.low || max_gear_limit !== e.lim ||
            shift_reject !== e.rej || gear_changed !== e.chg) begin
          bad++;
          $display("FAIL step%0d: got gear=%0d low=%0b lim=%0d rej=%0b chg=%0b want gear=%0d low=%0b lim=%0d rej=%0b chg=%0b",
                   e.id, current_gear, is_low_gear_mode, max_gear_limit, shift_reject, gear_changed,
                   e.gear, e.low, e.lim, e.rej, e.chg);
        end
      end else begin
        total++;
        if (shift_reject || gear_changed) begin
          bad++;
          $display("FAIL unexpected_pulse cyc=%0d: got rej=%0b chg=%0b want 0 0", cyc, shift_reject, gear_changed);
        end
      end
    end
  end

  task automatic set_btns(input logic [4:0] b);
    {btn_minus, btn_plus, btn_low, btn_down, btn_up} = b;
  endtask

  task automatic apply(input vec_t v, input int id);
    exp_t x;
    @(negedge clk);
    engine_on = v.eng;
    {is_brake_hard, is_brake_normal} = v.brk;
    speed = v.spd;
    set_btns(v.btn);
    x.due = (v.btn == 5'd0) ? cyc + 1 : cyc + DB + 3;
    x.id = id; x.gear = v.gear; x.low = v.low; x.lim = v.lim; x.rej = v.rej; x.chg = v.chg;
    sb.push_back(x);
    repeat (DB + 6) @(negedge clk);
    set_btns(5'd0);
    repeat (DB + 6) @(negedge clk);
  endtask

  task automatic check_now(input string name, input logic [3:0] g, input logic lo, input logic [2:0] li);
    total++;
    if (current_gear !== g || is_low_gear_mode !== lo || max_gear_limit !== li ||
        shift_reject !== 1'b0 || gear_changed !== 1'b0) begin
      bad++;
      $display("FAIL %s: got gear=%0d low=%0b lim=%0d rej=%0b chg=%0b want gear=%0d low=%0b lim=%0d rej=0 chg=0",
               name, current_gear, is_low_gear_mode, max_gear_limit, shift_reject, gear_changed, g, lo, li);
    end
  endtask

  initial begin
    add(DN, 1, NB, 0,   6, 0, 6, 0, 1);
    add(DN, 1, NB, 0,   9, 0, 6, 0, 1);
    add(DN, 1, NB, 0,  12, 0, 6, 0, 1);
    add(DN, 1, NB, 0,  12, 0, 6, 1, 0);
    add(U,  1, NOB, 40, 9, 0, 6, 0, 1);
    add(U,  1, NOB, 40, 9, 0, 6, 1, 0);
    add(DN, 1, NOB, 40, 12, 0, 6, 0, 1);
    add(LO, 1, NOB, 40, 12, 1, 3, 0, 0);
    add(PL, 1, NOB, 40, 12, 1, 4, 0, 0);
    add(PL, 1, NOB, 40, 12, 1, 5, 0, 0);
    add(PL, 1, NOB, 40, 12, 1, 6, 0, 0);
    add(PL, 1, NOB, 40, 12, 1, 6, 1, 0);
    add(MI, 1, NOB, 40, 12, 1, 5, 0, 0);
    add(PL | MI, 1, NOB, 40, 12, 1, 5, 0, 0);
    add(U,  1, NB, 0,   9, 0, 6, 0, 1);
    add(PL, 1, NB, 0,   9, 0, 6, 0, 0);
    add(LO, 1, NB, 0,   9, 0, 6, 1, 0);
    add(U,  1, NB, 3,   6, 0, 6, 0, 1);
    add(U,  1, NB, 3,   6, 0, 6, 1, 0);
    add(U,  1, NB, 0,   3, 0, 6, 0, 1);
    add(U,  1, NB, 0,   3, 0, 6, 1, 0);
    add(DN, 1, NOB, 0,  3, 0, 6, 1, 0);
    add(DN, 1, HB, 0,   6, 0, 6, 0, 1);
    add(DN, 1, NB, 0,   9, 0, 6, 0, 1);
    add(DN, 1, NB, 0,  12, 0, 6, 0, 1);
    add(LO, 1, NB, 0,  12, 1, 3, 0, 0);
    add(MI, 1, NB, 0,  12, 1, 2, 0, 0);
    add(MI, 1, NB, 0,  12, 1, 1, 0, 0);
    add(MI, 1, NB, 0,  12, 1, 1, 1, 0);
    add(U | DN, 1, NB, 0, 12, 1, 1, 1, 0);
    add(DN | LO, 1, NB, 0, 12, 1, 1, 1, 0);
    add(5'd0, 0, NB, 0,  3, 0, 6, 0, 1);
    add(DN, 0, NB, 0,   3, 0, 6, 0, 0);
    add(DN, 1, NB, 0,   6, 0, 6, 0, 1);

    repeat (3) @(negedge clk);
    check_now("reset_values", 4'd3, 1'b0, 3'd6);
    rst = 1'b0;
    engine_on = 1'b1;
    is_brake_normal = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Bounce shorter than the debounce window must not register
    @(negedge clk);
    btn_down = 1'b1;
    repeat (5) @(negedge clk);
    btn_down = 1'b0;
    repeat (DB + 10) @(negedge clk);
    check_now("short_bounce", 4'd6, 1'b0, 3'd6);

    begin
      vec_t v;
      exp_t x;
      v.btn = DN; v.eng = 1'b1; v.brk = NB; v.spd = 8'd0;
      v.gear = 4'd9; v.low = 1'b0; v.lim = 3'd6; v.rej = 1'b0; v.chg = 1'b1;
      apply(v, 100);
`ifdef GEAR_SELECTOR_AUTO_PARK_EN
      @(negedge clk);
      is_brake_normal = 1'b0;
      x.due = cyc + 14; x.id = 101; x.gear = 4'd3; x.low = 1'b0; x.lim = 3'd6; x.rej = 1'b0; x.chg = 1'b1;
      sb.push_back(x);
      repeat (5) @(negedge clk);
      is_brake_normal = 1'b1;
      @(negedge clk);
      is_brake_normal = 1'b0;
      repeat (20) @(negedge clk);
      check_now("auto_park", 4'd3, 1'b0, 3'd6);
      is_brake_normal = 1'b1;
      v.gear = 4'd6;
      apply(v, 102);
      x.gear = 4'd6;
`else
      @(negedge clk);
      is_brake_normal = 1'b0;
      repeat (40) @(negedge clk);
      check_now("n_held", 4'd9, 1'b0, 3'd6);
      is_brake_normal = 1'b1;
      v.gear = 4'd12;
      apply(v, 102);
      x.gear = 4'd12;
`endif
      check_now("pre_reset_gear", x.gear, 1'b0, 3'd6);
    end

    // Reset in the middle of a debounce discards the partial press
    @(negedge clk);
    btn_up = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check_now("async_reset", 4'd3, 1'b0, 3'd6);
    @(negedge clk);
    btn_up = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (DB + 10) @(negedge clk);
    check_now("after_reset", 4'd3, 1'b0, 3'd6);

    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
